uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART byte transmitter among `NUM_REQ` requesters. It captures the winning requester's byte and issues a one-cycle start pulse to the transmitter. It then tracks the transmitter's busy flag until the frame completes before serving the next request. It sits between the application-side byte sources and the `uart_tx`/`baud_tick_gen` pair in the UART subsystem.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width per requester.
- `TIMEOUT`, default 1024: cycles allowed for `tx_busy` to rise after `tx_start` (used only with the timeout feature).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  level request per requester; held with data stable until granted.
- `req_data`  in  NUM_REQ*DATA_W  packed bytes; requester i on bits [i*DATA_W +: DATA_W].
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- `owner`  out  $clog2(NUM_REQ)  index of the last granted requester.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W  captured byte, stable from grant until the next grant.
- `tx_busy`  in  1  high while the transmitter is shifting a frame.
- `arb_busy`  out  1  high in every state except IDLE.
- `tx_err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE. Encoding is held in the package.
- IDLE: if `|req` and `!tx_busy`, choose the winner by round robin. The search starts at `owner+1` modulo NUM_REQ and takes the first set `req` bit.
  - Load `tx_data` from the winner's slice, pulse `grant[winner]`, update `owner`, then go to START.
  - If `tx_busy` is high while in IDLE (a foreign frame is in progress), wait.
- START: assert `tx_start` for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: on `tx_busy`=1, go to WAIT_DONE.
- WAIT_DONE: on `tx_busy`=0, go to IDLE.
- Fairness: a requester that keeps `req` high is never granted twice while another request is pending.
- Only `req` bits sampled in IDLE matter. A `req` change in other states has no effect.
- A requester deasserting `req` before it is granted withdraws the request with no side effect.
- Reset values: state IDLE, `grant`=0, `tx_start`=0, `tx_data`=0, `owner`=NUM_REQ-1 (so requester 0 wins first), `arb_busy`=0, `tx_err`=0.
- Reset asserted mid-frame returns the block to IDLE immediately. Any frame already in the transmitter is not cancelled by this block.

## Timing
- All outputs are registered.
- Request path: `req[i]` high before edge k, in IDLE, with `tx_busy` low:
  - `grant[i]` and the new `tx_data` are valid after edge k.
  - `tx_start` is high after edge k+1 for one cycle.
  - The requester may drop `req` on seeing `grant`. It must drop `req` before the block next returns to IDLE or it is treated as a new request.
- Return to IDLE: `tx_busy` falling before edge m gives IDLE after m. The next grant is no earlier than edge m+1, so the minimum gap from `tx_busy` low to the next `tx_start` is 2 cycles.
- Simultaneous `req` bits resolve by the rotating pointer within the same cycle.
- `tx_busy` already high in START is caught at the WAIT_BUSY entry edge. Pass-through then takes one cycle.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- Defined: a counter of width $clog2(TIMEOUT+1) runs in WAIT_BUSY.
  - If the count reaches TIMEOUT with `tx_busy` still low, set `tx_err` and return to IDLE. The byte is dropped.
  - The counter clears on entry to WAIT_BUSY.
- Undefined: no counter. WAIT_BUSY waits indefinitely and `tx_err` is tied 0.

## Structure
- Package `uart_arb_pkg`: state enum type and reset constants for `owner` and `tx_data`.
- One sub-module, `rr_pick`: combinational round-robin search. It takes `req` and `owner` and returns `winner` index and `valid`.
- FSM, data capture and timeout stay in `uart_tx_arbiter`.

## Test plan
- Reset defaults: hold `rst_n`=0 → all outputs at reset values. Then `req`=4'b0001 with byte 0x30 → `grant`=0001 after one edge, `tx_start` pulse on the next edge, `tx_data`=0x30.
- Simultaneous requests: `req`=4'b1111 held, each cleared on its grant, transmitter model busy 10 cycles per byte → grant order 0,1,2,3 with `tx_data` 0x41,0x42,0x43,0x44.
- Fairness: requester 2 holds `req` continuously; requester 0 raises `req` during requester 2's frame → next grant goes to 0, then to 2.
- Busy gating: `tx_busy` forced high while in IDLE with `req`=0010 → no grant until `tx_busy` drops. Then the grant comes after 1 edge.
- Timeout (macro defined, TIMEOUT=16): `tx_busy` never rises → `tx_err`=1 at 16 cycles after WAIT_BUSY entry, and the FSM returns to IDLE. Rerun with the macro undefined → the FSM stays in WAIT_BUSY and `tx_err`=0.
- Mid-frame reset: pulse `rst_n` low during WAIT_DONE → outputs return to reset values asynchronously, and the first request after release is granted to requester 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and reset constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int TX_DATA_RST = 0;

  // Owner resets to the last index so the rotating search begins at requester 0.
  function automatic int owner_rst(input int num_req);
    return num_req - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at or after owner+1 (mod NUM_REQ).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      owner,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  int idx;

  always_comb begin
    winner = owner;
    valid  = 1'b0;
    idx    = 0;
    // Offsets 1..NUM_REQ visit every requester once, the current owner last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(owner) + i) % NUM_REQ;
      if (!valid && req[IW'(idx)]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ sources.
// Optional WAIT_BUSY timeout with sticky tx_err when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic                        arb_busy,
  output logic                        tx_err
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_chk
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  arb_state_e                      state_q, state_d;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_bytes;
  logic [IW-1:0]                   pick_idx;
  logic                            pick_vld;
  logic                            take;
  logic                            to_hit;

  assign req_bytes = req_data;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .owner  (owner),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  // A foreign frame on the line (tx_busy in IDLE) holds off arbitration.
  assign take = (state_q == ST_IDLE) && pick_vld && !tx_busy;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] to_cnt;

  assign to_hit = (state_q == ST_WAIT_BUSY) && !tx_busy && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      tx_err <= 1'b0;
    end else begin
      to_cnt <= (state_q == ST_WAIT_BUSY) ? to_cnt + 1'b1 : '0;
      tx_err <= tx_err | to_hit;
    end
  end
`else
  assign to_hit = 1'b0;
  assign tx_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (take) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy) state_d = ST_WAIT_DONE;
                    else if (to_hit) state_d = ST_IDLE;
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant    <= '0;
      owner    <= IW'(owner_rst(NUM_REQ));
      tx_start <= 1'b0;
      tx_data  <= DATA_W'(TX_DATA_RST);
      arb_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant    <= '0;
      tx_start <= (state_q == ST_START);
      arb_busy <= (state_d != ST_IDLE);
      if (take) begin
        grant[pick_idx] <= 1'b1;
        owner           <= pick_idx;
        tx_data         <= req_bytes[pick_idx];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; expected grants queued by stimulus, checked by a monitor.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     grant;
  logic [1:0]       owner;
  logic             tx_start;
  logic [W-1:0]     tx_data;
  logic             tx_busy;
  logic             arb_busy;
  logic             tx_err;
  logic             force_busy;
  logic             model_en;
  int               mcnt = 0;

  typedef struct { int idx; logic [W-1:0] data; } exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
    .owner(owner), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .arb_busy(arb_busy), .tx_err(tx_err)
  );

  // Transmitter model: busy for 10 cycles after each start pulse.
  always @(posedge clk) begin
    if (model_en && tx_start) mcnt <= 10;
    else if (mcnt != 0)       mcnt <= mcnt - 1;
  end
  assign tx_busy = force_busy | (mcnt != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int i, input logic [W-1:0] d);
    exp_t e;
    e.idx = i;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic set_byte(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask

  task automatic wait_grant(input int budget, input bit drop);
    int n;
    n = 0;
    @(negedge clk);
    while (grant == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (grant == '0) chk("grant_wait_expired", 32'd0, 32'd1);
    else if (drop) req = req & ~grant;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (arb_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, arb_busy}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per grant, then expects tx_start on the next cycle.
  initial begin : monitor
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      else begin
        if (pend) begin
          chk("tx_start_after_grant", {31'd0, tx_start}, 32'd1);
          pend = 1'b0;
        end
        if (grant != '0) begin
          if (exp_q.size() == 0) chk("unexpected_grant", {28'd0, grant}, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("grant", {28'd0, grant}, 32'd1 << e.idx);
            chk("tx_data", {24'd0, tx_data}, {24'd0, e.data});
            chk("owner", {30'd0, owner}, e.idx);
            chk("tx_start_with_grant", {31'd0, tx_start}, 32'd0);
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin : stim
    req = '0;
    req_data = '0;
    force_busy = 1'b0;
    model_en = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd3);
    chk("rst_arb_busy", {31'd0, arb_busy}, 32'd0);
    chk("rst_tx_err", {31'd0, tx_err}, 32'd0);
    rst_n = 1'b1;

    // Single request: grant after one edge, start pulse after the next.
    @(negedge clk);
    set_byte(0, 8'h30);
    req = 4'b0001;
    push_exp(0, 8'h30);
    @(posedge clk); #1;
    chk("t1_grant_latency", {28'd0, grant}, 32'h1);
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    chk("t1_tx_start", {31'd0, tx_start}, 32'd1);
    chk("t1_tx_data", {24'd0, tx_data}, 32'h30);
    chk("t1_arb_busy", {31'd0, arb_busy}, 32'd1);
    @(posedge clk); #1;
    chk("t1_start_one_cycle", {31'd0, tx_start}, 32'd0);
    wait_idle(50);

    // All four at once from reset: order 0,1,2,3.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      set_byte(i, 8'h41 + 8'(i));
      push_exp(i, 8'h41 + 8'(i));
    end
    req = 4'b1111;
    repeat (N) wait_grant(60, 1'b1);
    wait_idle(60);

    // Fairness: requester 2 holds req; requester 0 joins mid-frame.
    set_byte(2, 8'h52);
    req = 4'b0100;
    push_exp(2, 8'h52);
    wait_grant(20, 1'b0);
    repeat (3) @(negedge clk);
    set_byte(0, 8'h50);
    req[0] = 1'b1;
    push_exp(0, 8'h50);
    push_exp(2, 8'h52);
    wait_grant(60, 1'b1);
    wait_grant(60, 1'b1);
    wait_idle(60);

    // Busy gating: no grant while a foreign frame holds tx_busy.
    force_busy = 1'b1;
    @(negedge clk);
    set_byte(1, 8'h62);
    req = 4'b0010;
    repeat (5) @(negedge clk);
    chk("t4_no_grant_busy", {28'd0, grant}, 32'd0);
    chk("t4_idle_while_busy", {31'd0, arb_busy}, 32'd0);
    push_exp(1, 8'h62);
    force_busy = 1'b0;
    @(posedge clk); #1;
    chk("t4_grant_after_busy", {28'd0, grant}, 32'h2);
    @(negedge clk);
    req = '0;
    wait_idle(60);

    // Transmitter never answers.
    model_en = 1'b0;
    set_byte(0, 8'h71);
    req = 4'b0001;
    push_exp(0, 8'h71);
    wait_grant(20, 1'b1);
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1;
    chk("t5_err_before", {31'd0, tx_err}, 32'd0);
    chk("t5_busy_before", {31'd0, arb_busy}, 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
    @(posedge clk); #1;
    chk("t5_err_set", {31'd0, tx_err}, 32'd1);
    chk("t5_back_idle", {31'd0, arb_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_err_sticky", {31'd0, tx_err}, 32'd1);
`else
    repeat (15) @(posedge clk);
    #1;
    chk("t5_no_err", {31'd0, tx_err}, 32'd0);
    chk("t5_still_waiting", {31'd0, arb_busy}, 32'd1);
    @(negedge clk);
    force_busy = 1'b1;
    @(negedge clk);
    force_busy = 1'b0;
    wait_idle(20);
`endif
    model_en = 1'b1;

    // Reset during WAIT_DONE, then requester 0 must win first.
    set_byte(2, 8'h83);
    req = 4'b0100;
    push_exp(2, 8'h83);
    wait_grant(20, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_grant", {28'd0, grant}, 32'd0);
    chk("t6_tx_start", {31'd0, tx_start}, 32'd0);
    chk("t6_tx_data", {24'd0, tx_data}, 32'd0);
    chk("t6_owner", {30'd0, owner}, 32'd3);
    chk("t6_arb_busy", {31'd0, arb_busy}, 32'd0);
    chk("t6_tx_err", {31'd0, tx_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_byte(0, 8'h90);
    set_byte(3, 8'h93);
    req = 4'b1001;
    push_exp(0, 8'h90);
    wait_grant(40, 1'b1);
    req = '0;
    wait_idle(60);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
